stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N-channel registered stream multiplexer with valid/ready handshakes.
//  Generalises the 2:1 mux in width and channel count. Adds a fixed-select mode and a
//  round-robin arbitration mode, with one registered output stage.
//  Sits between multiple producer streams and a single consumer.
// PARAMETERS
//  WIDTH  8  data bits per channel
//  NCH    4  number of input channels, >=2
//  SELW   2  select/channel-id width, must equal $clog2(NCH)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, synchronous, active-high
//  mode       in   1          0 = fixed select via sel; 1 = round-robin
//  sel        in   SELW       channel used in fixed mode; sel>=NCH selects nothing
//  in_valid   in   NCH        per-channel valid
//  in_data    in   NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_ready   out  NCH        per-channel ready; at most one bit high per cycle
//  out_valid  out  1          output register holds a beat
//  out_data   out  WIDTH      registered data
//  out_ch     out  SELW       source channel of the held beat
//  out_ready  in   1          consumer accepts the beat when out_valid & out_ready
//  beat_cnt   out  16         accepted-beat counter, only with STREAM_MUX_CNT_EN
// BEHAVIOUR
//  - Reset: clk and rst as above, synchronous active-high.
//    out_valid=0, out_data=0, out_ch=0, rr_ptr=0, beat_cnt=0, state=EMPTY.
//  - Output-stage FSM:
//    EMPTY: output register holds no beat.
//    FULL: output register holds a beat.
//  - load = (state==EMPTY) | out_ready. The output register captures a beat only when load=1.
//  - Grant g is combinational:
//    fixed mode: g=sel if sel<NCH and in_valid[sel]=1, else no grant.
//    RR mode: g is the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ...,
//    wrapping modulo NCH. No grant when no input is valid.
//  - in_ready[g]=load. All other in_ready bits are 0. in_ready never depends on in_valid
//    of a different channel outside the grant logic.
//  - Transfer on channel g when in_valid[g] & in_ready[g]. On the next edge:
//    out_data<=in_data[g], out_ch<=g, state->FULL.
//  - In RR mode, each transfer sets rr_ptr<=(g+1) mod NCH; the wrap goes NCH-1 -> 0.
//    rr_ptr is unchanged in fixed mode and on cycles with no transfer.
//  - FULL & out_ready & no grant -> EMPTY.
//    FULL & out_ready & grant -> stays FULL with the new beat. This gives back-to-back
//    throughput of 1 beat/clk.
//  - FULL & !out_ready: out_valid, out_data and out_ch stay stable. All in_ready are 0.
//  - Latency: input transfer at edge k -> out_valid=1 after edge k, visible in cycle k+1.
//  - mode or sel may change on any cycle. The change affects only the next grant and never
//    alters a held beat.
//  - rst asserted mid-operation drops any held beat. All state returns to reset values on
//    that edge.
// CONFIGURATION
//  - STREAM_MUX_CNT_EN defined:
//    beat_cnt increments on each output handshake (out_valid & out_ready).
//    It saturates at 16'hFFFF and clears on rst.
//  - STREAM_MUX_CNT_EN undefined:
//    the beat_cnt port and counter logic are absent. All other behaviour is identical.
// TESTING
//  1. rst=1 for 2 clk -> out_valid=0, out_data=0, out_ch=0, in_ready=0000 when no input is valid.
//  2. mode=0, sel=2, in_valid=1111, ch2=8'hA5, out_ready=1 ->
//     in_ready=0100; next cycle out_valid=1, out_data=A5, out_ch=2.
//  3. mode=1, all valid, out_ready=1 held 8 clk -> out_ch sequence 0,1,2,3,0,1,2,3.
//     One beat per clock, no bubbles.
//  4. mode=1, in_valid=1010, rr_ptr=2 -> grant ch3, then ch1 (wrap past 0), then ch3.
//  5. Beat held with out_ready=0 for 5 clk -> out_data/out_ch stable, in_ready=0000.
//     Release -> next beat loads on the same edge the held beat leaves.
//  6. rst pulsed while FULL -> out_valid=0 next cycle. With STREAM_MUX_CNT_EN:
//     beat_cnt=0 after reset, and it reads 3 after 3 handshakes.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N producer channels and one consumer.
// The mux owns the slave side; producers/consumer drive the master side.
interface stream_mux_rr_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux, fixed-select or round-robin grant.
// Define STREAM_MUX_CNT_EN to add the saturating beat_cnt port.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    stream_mux_rr_if.slave  s
`ifdef STREAM_MUX_CNT_EN
    ,
    output logic [15:0]     beat_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0] ch_q;

    logic            load;
    logic            xfer;
    logic            fix_vld, rr_vld, gnt_vld;
    logic [SELW-1:0] fix_gnt, rr_gnt, gnt;
    logic [WIDTH-1:0] gnt_data;

    assign load = (state_q == EMPTY) | s.out_ready;

    // sel values at or above NCH match no channel and so grant nothing
    always_comb begin
        fix_vld = 1'b0;
        fix_gnt = sel;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i)) fix_vld = s.in_valid[i];
        end
    end

    // Scan from the far end so the candidate nearest rr_ptr is written last
    always_comb begin
        rr_vld = 1'b0;
        rr_gnt = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NCH;
            if (s.in_valid[idx]) begin
                rr_vld = 1'b1;
                rr_gnt = SELW'(idx);
            end
        end
    end

    always_comb begin
        gnt_vld = fix_vld;
        gnt     = fix_gnt;
        if (mode) begin
            gnt_vld = rr_vld;
            gnt     = rr_gnt;
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt == SELW'(i)) gnt_data = s.in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        s.in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            s.in_ready[i] = gnt_vld & load & (gnt == SELW'(i));
        end
    end

    assign xfer = gnt_vld & load;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (s.out_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (xfer && mode) begin
            if (gnt == SELW'(NCH - 1)) rr_ptr_d = '0;
            else rr_ptr_d = gnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            data_q   <= '0;
            ch_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (xfer) begin
                data_q <= gnt_data;
                ch_q   <= gnt;
            end
        end
    end

    assign s.out_valid = (state_q == FULL);
    assign s.out_data  = data_q;
    assign s.out_ch    = ch_q;

`ifdef STREAM_MUX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (s.out_valid && s.out_ready && beat_cnt != 16'hFFFF) begin
            beat_cnt <= beat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_stream_mux_rr;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic            clk;
    logic            rst;
    logic            mode;
    logic [SELW-1:0] sel;
`ifdef STREAM_MUX_CNT_EN
    logic [15:0]     beat_cnt;
`endif

    stream_mux_rr_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();

    stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .sel  (sel),
        .s    (bus)
`ifdef STREAM_MUX_CNT_EN
        ,
        .beat_cnt (beat_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents of the output register after the last edge
    bit   m_valid = 1'b0;
    int   m_ch    = 0;
    int   m_data  = 0;
    int   m_ptr   = 0;
    int   m_cnt   = 0;

    function automatic int exp_grant();
        if (!mode) begin
            if (int'(sel) < NCH && bus.in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_ptr + k) % NCH;
            if (bus.in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Inputs only change just after a rising edge, so at the falling edge
    // they are the values the next rising edge will sample.
    always @(negedge clk) begin
        int g;
        bit ld;
        logic [NCH-1:0] er;
        ld = !m_valid || bus.out_ready;
        g  = exp_grant();
        er = '0;
        if (g >= 0 && ld) er[g] = 1'b1;
        if (chk_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(er));
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                check("out_data", 32'(bus.out_data), 32'(m_data));
                check("out_ch", 32'(bus.out_ch), 32'(m_ch));
            end
`ifdef STREAM_MUX_CNT_EN
            check("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
`endif
        end
        if (rst) begin
            m_valid = 1'b0;
            m_ch    = 0;
            m_data  = 0;
            m_ptr   = 0;
            m_cnt   = 0;
        end else begin
            if (m_valid && bus.out_ready && m_cnt < 65535) m_cnt++;
            if (g >= 0 && ld) begin
                m_valid = 1'b1;
                m_ch    = g;
                m_data  = int'(bus.in_data[g*WIDTH +: WIDTH]);
                if (mode) m_ptr = (g + 1) % NCH;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_exp [3] = '{3, 1, 3};

    initial begin
        rst           = 1'b1;
        mode          = 1'b0;
        sel           = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // reset held for two edges
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_ch", 32'(bus.out_ch), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef STREAM_MUX_CNT_EN
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif

        // fixed select of channel 2
        tick();
        mode          = 1'b0;
        sel           = 2'd2;
        bus.in_valid  = 4'b1111;
        bus.in_data   = 32'h44A5_2211;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("fix_in_ready", 32'(bus.in_ready), 32'b0100);
        tick();
        bus.in_valid = '0;
        @(negedge clk);
        check("fix_out_valid", 32'(bus.out_valid), 32'd1);
        check("fix_out_data", 32'(bus.out_data), 32'hA5);
        check("fix_out_ch", 32'(bus.out_ch), 32'd2);
        tick();

        // round robin with all channels valid: one beat per clock
        mode         = 1'b1;
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) bus.in_valid = '0;
            @(negedge clk);
            check("rr_seq_ch", 32'(bus.out_ch), 32'(i % 4));
            check("rr_seq_valid", 32'(bus.out_valid), 32'd1);
        end

        // pointer moved to 2, then channels 3 and 1 alternate across the wrap
        tick();
        bus.in_valid = 4'b0010;
        tick();
        bus.in_valid = 4'b1010;
        @(negedge clk);
        check("rr_ptr_setup_ch", 32'(bus.out_ch), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) begin
                bus.in_valid  = 4'b1111;
                bus.out_ready = 1'b0;
            end
            @(negedge clk);
            check("rr_wrap_ch", 32'(bus.out_ch), 32'(rr_exp[i]));
        end

        // back-pressure: held beat stays put and no channel is ready
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_ch", 32'(bus.out_ch), 32'd3);
            check("hold_data", 32'(bus.out_data), 32'h44);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(bus.in_ready), 32'b0001);
        tick();
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("release_ch", 32'(bus.out_ch), 32'd0);
        check("release_data", 32'(bus.out_data), 32'h11);

        // reset while a beat is held, then three handshakes
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
`ifdef STREAM_MUX_CNT_EN
        check("midrst_cnt", 32'(beat_cnt), 32'd0);
`endif
        tick();
        mode          = 1'b0;
        sel           = 2'd1;
        bus.in_valid  = 4'b0010;
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.in_valid = '0;
        tick();
        @(negedge clk);
        check("cnt_phase_valid", 32'(bus.out_valid), 32'd0);
`ifdef STREAM_MUX_CNT_EN
        check("cnt_after3", 32'(beat_cnt), 32'd3);
`endif

        // random traffic with occasional resets and mode/sel changes
        repeat (3000) begin
            tick();
            rst           = ($urandom_range(0, 99) == 0);
            mode          = 1'($urandom);
            sel           = SELW'($urandom);
            bus.in_valid  = NCH'($urandom);
            bus.in_data   = (NCH*WIDTH)'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
